// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MW_READ = 2'b00;
  localparam logic [1:0] MW_W32  = 2'b01;
  localparam logic [1:0] MW_W64  = 2'b10;

  localparam int OFF_W = 3;

  function automatic logic is_write(input logic [1:0] mw);
    return mw != MW_READ;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for dcache: synchronous write, combinational read.
module dcache_array #(
  parameter int N     = 64,
  parameter int LINES = 16,
  parameter int IW    = 4,
  parameter int TW    = 25
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] index,
  input  logic [TW-1:0] wtag,
  input  logic          we,
  input  logic [1:0]    wmask,
  input  logic [N-1:0]  wdata,
  output logic          rvalid,
  output logic [TW-1:0] rtag,
  output logic [N-1:0]  rdata
);

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags [LINES];
  logic [N-1:0]     data [LINES];

  always_ff @(posedge clk) begin
    if (reset)
      valid <= '0;
    else if (we)
      valid[index] <= 1'b1;
  end

  // Tag and data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[index] <= wtag;
      if (wmask[0]) data[index][31:0]  <= wdata[31:0];
      if (wmask[1]) data[index][N-1:32] <= wdata[N-1:32];
    end
  end

  assign rvalid = valid[index];
  assign rtag   = tags[index];
  assign rdata  = data[index];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
module dcache
  import dcache_pkg::*;
#(
  parameter int N     = 64,
  parameter int LINES = 16,
  parameter int AW    = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic [1:0]   cpu_memwrite,
  input  logic [N-1:0] cpu_adr,
  input  logic [N-1:0] cpu_wdata,
  output logic [N-1:0] cpu_rdata,
  output logic         cpu_abort,
  output logic         hit,
  output logic         mem_req,
  output logic [1:0]   mem_memwrite,
  output logic [N-1:0] mem_adr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_val
);

  localparam int IW = $clog2(LINES);
  localparam int TW = AW - OFF_W - IW;

  state_t state, next_state;

  logic [N-1:0]  lat_adr;
  logic [N-1:0]  lat_wdata;
  logic [1:0]    lat_mw;

  logic [N-1:0]  lk_adr;
  logic [IW-1:0] lk_idx;
  logic [TW-1:0] lk_tag;
  logic          lk_hit;
  logic          rd_hit;
  logic          start;

  logic          arr_rvalid;
  logic [TW-1:0] arr_rtag;
  logic [N-1:0]  arr_rdata;
  logic          arr_we;
  logic [1:0]    arr_wmask;
  logic [N-1:0]  arr_wdata;

  logic          unused_adr;

  // Once a transaction is in flight the latch, not the core, addresses the array.
  assign lk_adr = (state == IDLE) ? cpu_adr : lat_adr;
  assign lk_idx = lk_adr[OFF_W+IW-1:OFF_W];
  assign lk_tag = lk_adr[AW-1:OFF_W+IW];
  assign lk_hit = arr_rvalid && (arr_rtag == lk_tag);
  assign unused_adr = ^{lk_adr[N-1:AW], lk_adr[OFF_W-1:0]};

  assign rd_hit = cpu_req && !is_write(cpu_memwrite) && lk_hit;
  assign start  = (state == IDLE) && cpu_req && !rd_hit;

  dcache_array #(
    .N     (N),
    .LINES (LINES),
    .IW    (IW),
    .TW    (TW)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .index  (lk_idx),
    .wtag   (lk_tag),
    .we     (arr_we),
    .wmask  (arr_wmask),
    .wdata  (arr_wdata),
    .rvalid (arr_rvalid),
    .rtag   (arr_rtag),
    .rdata  (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_adr   <= '0;
      lat_wdata <= '0;
      lat_mw    <= MW_READ;
    end else if (start) begin
      lat_adr   <= cpu_adr;
      lat_wdata <= cpu_wdata;
      lat_mw    <= cpu_memwrite;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = is_write(cpu_memwrite) ? WRITE : FILL;
      FILL:  if (mem_val) next_state = DONE;
      WRITE: if (mem_val) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cpu_abort    = 1'b0;
    mem_req      = 1'b0;
    mem_memwrite = MW_READ;
    mem_adr      = lat_adr;
    mem_wdata    = lat_wdata;
    hit          = 1'b0;
    cpu_rdata    = '0;
    arr_we       = 1'b0;
    arr_wmask    = 2'b11;
    arr_wdata    = mem_rdata;
    if (!reset) begin
      hit       = lk_hit;
      cpu_rdata = arr_rdata;
      case (state)
        IDLE: cpu_abort = start;
        FILL: begin
          cpu_abort = 1'b1;
          mem_req   = 1'b1;
          mem_adr   = {lat_adr[N-1:OFF_W], {OFF_W{1'b0}}};
          arr_we    = mem_val;
        end
        WRITE: begin
          cpu_abort    = 1'b1;
          mem_req      = 1'b1;
          mem_memwrite = lat_mw;
          arr_we       = mem_val && lk_hit;
          if (lat_mw == MW_W32) begin
            arr_wmask = lat_adr[2] ? 2'b10 : 2'b01;
            arr_wdata = {lat_wdata[31:0], lat_wdata[31:0]};
          end else begin
            arr_wdata = lat_wdata;
          end
        end
        default: cpu_abort = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Scenario bench for dcache: a small memory responder plus an expected-read queue.
module tb_dcache;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [1:0]  cpu_memwrite;
  logic [63:0] cpu_adr;
  logic [63:0] cpu_wdata;
  logic [63:0] cpu_rdata;
  logic        cpu_abort;
  logic        hit;
  logic        mem_req;
  logic [1:0]  mem_memwrite;
  logic [63:0] mem_adr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_val;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [63:0] exp_q[$];

  dcache dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_memwrite (cpu_memwrite),
    .cpu_adr      (cpu_adr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_abort    (cpu_abort),
    .hit          (hit),
    .mem_req      (mem_req),
    .mem_memwrite (mem_memwrite),
    .mem_adr      (mem_adr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_val      (mem_val)
  );

  always #5 clk = ~clk;

  // Issues one core access, answers memory after `delay` mem_req cycles, reports observations.
  task automatic access(input logic [63:0] adr, input logic [1:0] mw, input logic [63:0] wd,
                        input logic [63:0] mrd, input int delay, input bit chg,
                        output int aborts, output bit saw_req, output logic [63:0] madr,
                        output logic [1:0] mmw, output logic [63:0] rd, output bit stable,
                        output bit timeout);
    int cnt;
    bit done;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_memwrite = mw; cpu_adr = adr; cpu_wdata = wd;
    aborts = 0; saw_req = 1'b0; madr = '0; mmw = '0; rd = '0;
    stable = 1'b1; timeout = 1'b0; cnt = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_req) begin
        if (!saw_req) begin
          madr = mem_adr;
          mmw  = mem_memwrite;
        end else if (mem_adr !== madr) begin
          stable = 1'b0;
        end
        saw_req = 1'b1;
        cnt++;
      end
      if (!cpu_abort) begin
        rd = cpu_rdata;
        done = 1'b1;
      end else begin
        aborts++;
        if (mem_req && cnt == delay) begin
          mem_val = 1'b1;
          mem_rdata = mrd;
        end
        @(posedge clk); #1;
        mem_val = 1'b0;
        if (chg && saw_req) cpu_adr = adr ^ 64'h1000;
      end
    end
    if (!done) timeout = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_memwrite = 2'b00; cpu_adr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_req = 1'b1; cpu_memwrite = 2'b00; cpu_adr = 64'h40;
    cpu_wdata = '0; mem_val = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (cpu_abort !== 1'b0) $display("FAIL reset_abort: got %b want 0", cpu_abort); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else pass_cnt++;
    total_cnt++; if (hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", hit); else pass_cnt++;
    total_cnt++; if (mem_memwrite !== 2'b00) $display("FAIL reset_memwrite: got %b want 00", mem_memwrite); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 64'h0) $display("FAIL reset_rdata: got %h want 0", cpu_rdata); else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 1'b0; mem_val = 1'b0;
    @(negedge clk);
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL idle_mem_req: got %b want 0", mem_req); else pass_cnt++;
  endtask

  task automatic test_cold_read();
    int ab; bit sr, st, to; logic [63:0] ma, rd, ex; logic [1:0] mm;
    exp_q.push_back(64'h1122334455667788);
    access(64'h40, 2'b00, '0, 64'h1122334455667788, 3, 1'b0, ab, sr, ma, mm, rd, st, to);
    ex = exp_q.pop_front();
    total_cnt++; if (to !== 1'b0) $display("FAIL cold_timeout: got %b want 0", to); else pass_cnt++;
    total_cnt++; if (ab !== 4) $display("FAIL cold_abort_cycles: got %0d want 4", ab); else pass_cnt++;
    total_cnt++; if (ma !== 64'h40) $display("FAIL cold_mem_adr: got %h want 40", ma); else pass_cnt++;
    total_cnt++; if (mm !== 2'b00) $display("FAIL cold_memwrite: got %b want 00", mm); else pass_cnt++;
    total_cnt++; if (rd !== ex) $display("FAIL cold_rdata: got %h want %h", rd, ex); else pass_cnt++;
    exp_q.push_back(64'h1122334455667788);
    access(64'h44, 2'b00, '0, '0, 1, 1'b0, ab, sr, ma, mm, rd, st, to);
    ex = exp_q.pop_front();
    total_cnt++; if (ab !== 0) $display("FAIL hit_abort_cycles: got %0d want 0", ab); else pass_cnt++;
    total_cnt++; if (sr !== 1'b0) $display("FAIL hit_mem_req: got %b want 0", sr); else pass_cnt++;
    total_cnt++; if (rd !== ex) $display("FAIL hit_rdata: got %h want %h", rd, ex); else pass_cnt++;
  endtask

  task automatic test_write_hit32();
    int ab; bit sr, st, to; logic [63:0] ma, rd, ex; logic [1:0] mm;
    access(64'h44, 2'b01, 64'h0000_0000_DEAD_BEEF, '0, 1, 1'b0, ab, sr, ma, mm, rd, st, to);
    total_cnt++; if (ma !== 64'h44) $display("FAIL w32_mem_adr: got %h want 44", ma); else pass_cnt++;
    total_cnt++; if (mm !== 2'b01) $display("FAIL w32_memwrite: got %b want 01", mm); else pass_cnt++;
    total_cnt++; if (ab !== 2) $display("FAIL w32_abort_cycles: got %0d want 2", ab); else pass_cnt++;
    exp_q.push_back(64'hDEADBEEF55667788);
    access(64'h40, 2'b00, '0, '0, 1, 1'b0, ab, sr, ma, mm, rd, st, to);
    ex = exp_q.pop_front();
    total_cnt++; if (sr !== 1'b0) $display("FAIL w32_reread_mem_req: got %b want 0", sr); else pass_cnt++;
    total_cnt++; if (rd !== ex) $display("FAIL w32_reread_rdata: got %h want %h", rd, ex); else pass_cnt++;
  endtask

  task automatic test_write_miss();
    int ab; bit sr, st, to; logic [63:0] ma, rd, ex; logic [1:0] mm;
    access(64'h80, 2'b10, 64'hCAFE_F00D_1234_5678, '0, 2, 1'b0, ab, sr, ma, mm, rd, st, to);
    total_cnt++; if (sr !== 1'b1) $display("FAIL wmiss_mem_req: got %b want 1", sr); else pass_cnt++;
    total_cnt++; if (ma !== 64'h80) $display("FAIL wmiss_mem_adr: got %h want 80", ma); else pass_cnt++;
    total_cnt++; if (mm !== 2'b10) $display("FAIL wmiss_memwrite: got %b want 10", mm); else pass_cnt++;
    exp_q.push_back(64'h0102030405060708);
    access(64'h80, 2'b00, '0, 64'h0102030405060708, 1, 1'b0, ab, sr, ma, mm, rd, st, to);
    ex = exp_q.pop_front();
    total_cnt++; if (sr !== 1'b1) $display("FAIL wmiss_read_fill: got %b want 1", sr); else pass_cnt++;
    total_cnt++; if (ab !== 2) $display("FAIL wmiss_read_aborts: got %0d want 2", ab); else pass_cnt++;
    total_cnt++; if (rd !== ex) $display("FAIL wmiss_read_rdata: got %h want %h", rd, ex); else pass_cnt++;
  endtask

  task automatic test_conflict();
    int ab; bit sr, st, to; logic [63:0] ma, rd, ex; logic [1:0] mm;
    exp_q.push_back(64'hA5A5_5A5A_0F0F_F0F0);
    access(64'hC4, 2'b00, '0, 64'hA5A5_5A5A_0F0F_F0F0, 1, 1'b0, ab, sr, ma, mm, rd, st, to);
    ex = exp_q.pop_front();
    total_cnt++; if (sr !== 1'b1) $display("FAIL conflict_fill: got %b want 1", sr); else pass_cnt++;
    total_cnt++; if (ma !== 64'hC0) $display("FAIL conflict_aligned_adr: got %h want c0", ma); else pass_cnt++;
    total_cnt++; if (rd !== ex) $display("FAIL conflict_rdata: got %h want %h", rd, ex); else pass_cnt++;
    exp_q.push_back(64'h7777_6666_5555_4444);
    access(64'h40, 2'b00, '0, 64'h7777_6666_5555_4444, 1, 1'b0, ab, sr, ma, mm, rd, st, to);
    ex = exp_q.pop_front();
    total_cnt++; if (sr !== 1'b1) $display("FAIL evicted_refill: got %b want 1", sr); else pass_cnt++;
    total_cnt++; if (ab !== 2) $display("FAIL evicted_aborts: got %0d want 2", ab); else pass_cnt++;
    total_cnt++; if (rd !== ex) $display("FAIL evicted_rdata: got %h want %h", rd, ex); else pass_cnt++;
  endtask

  task automatic test_write_halves();
    int ab; bit sr, st, to; logic [63:0] ma, rd, ex; logic [1:0] mm;
    access(64'h40, 2'b01, 64'hFFFF_FFFF_1234_5678, '0, 1, 1'b0, ab, sr, ma, mm, rd, st, to);
    exp_q.push_back(64'h7777_6666_1234_5678);
    access(64'h40, 2'b00, '0, '0, 1, 1'b0, ab, sr, ma, mm, rd, st, to);
    ex = exp_q.pop_front();
    total_cnt++; if (rd !== ex) $display("FAIL w32_lower_rdata: got %h want %h", rd, ex); else pass_cnt++;
    access(64'h80, 2'b11, 64'h5555_AAAA_5555_AAAA, '0, 1, 1'b0, ab, sr, ma, mm, rd, st, to);
    total_cnt++; if (mm !== 2'b11) $display("FAIL w64_memwrite: got %b want 11", mm); else pass_cnt++;
    exp_q.push_back(64'h5555_AAAA_5555_AAAA);
    access(64'h80, 2'b00, '0, '0, 1, 1'b0, ab, sr, ma, mm, rd, st, to);
    ex = exp_q.pop_front();
    total_cnt++; if (sr !== 1'b0) $display("FAIL w64_reread_mem_req: got %b want 0", sr); else pass_cnt++;
    total_cnt++; if (rd !== ex) $display("FAIL w64_reread_rdata: got %h want %h", rd, ex); else pass_cnt++;
  endtask

  task automatic test_reset_mid_fill();
    int ab; bit sr, st, to; logic [63:0] ma, rd, ex; logic [1:0] mm;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_memwrite = 2'b00; cpu_adr = 64'h100;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL midfill_req: got %b want 1", mem_req); else pass_cnt++;
    reset = 1'b1; mem_val = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk); #1;
    mem_val = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL midfill_reset_req: got %b want 0", mem_req); else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (mem_req !== 1'b0 || cpu_abort !== 1'b0) $display("FAIL midfill_idle: got req=%b abort=%b want 0 0", mem_req, cpu_abort); else pass_cnt++;
    exp_q.push_back(64'h0BAD_CAFE_0000_0001);
    access(64'h100, 2'b00, '0, 64'h0BAD_CAFE_0000_0001, 1, 1'b0, ab, sr, ma, mm, rd, st, to);
    ex = exp_q.pop_front();
    total_cnt++; if (sr !== 1'b1 || ab !== 2) $display("FAIL midfill_remiss: got req=%b aborts=%0d want 1 2", sr, ab); else pass_cnt++;
    total_cnt++; if (rd !== ex) $display("FAIL midfill_rdata: got %h want %h", rd, ex); else pass_cnt++;
  endtask

  task automatic test_stable_stall();
    int ab; bit sr, st, to; logic [63:0] ma, rd; logic [1:0] mm;
    access(64'h200, 2'b10, 64'h1357_9BDF_2468_ACE0, '0, 4, 1'b1, ab, sr, ma, mm, rd, st, to);
    total_cnt++; if (to !== 1'b0) $display("FAIL stall_timeout: got %b want 0", to); else pass_cnt++;
    total_cnt++; if (ma !== 64'h200) $display("FAIL stall_mem_adr: got %h want 200", ma); else pass_cnt++;
    total_cnt++; if (st !== 1'b1) $display("FAIL stall_adr_stable: got %b want 1", st); else pass_cnt++;
    total_cnt++; if (ab !== 5) $display("FAIL stall_aborts: got %0d want 5", ab); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit32();
    test_write_miss();
    test_conflict();
    test_write_halves();
    test_reset_mid_fill();
    test_stable_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
